data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Word-organised data memory with byte/half/word load-store access, alignment and range
// checking, one-cycle response latency and a self-clearing INIT sweep after reset.
module data_mem_ctrl #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_done,
  output logic [7:0]        err_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  clr_idx_q, clr_idx_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [31:0]    rsp_rdata_q, rsp_rdata_d;
  logic           rsp_err_q, rsp_err_d;
  logic [7:0]     err_cnt_q, err_cnt_d;

  logic [31:0]    mem [DEPTH];

  // Request decode
  logic           accept;
  logic [AW-1:0]  word_idx;
  logic [1:0]     offset;
  logic           out_of_range;
  logic           misaligned;
  logic           req_err;

  assign accept       = req_valid && (state_q == ST_RUN);
  assign word_idx     = req_addr[AW+1:2];
  assign offset       = req_addr[1:0];
  assign out_of_range = (req_addr >> 2) >= ADDR_W'(DEPTH);
  assign misaligned   = ((req_size == SZ_HALF) && offset[0]) ||
                        ((req_size == SZ_WORD) && (offset != 2'b00));
  assign req_err      = (req_size == SZ_ILL) || misaligned || out_of_range;

  // Load path: move the addressed lane(s) down to bit 0, then extend.
  logic [31:0] rd_word;
  logic [31:0] rd_shift;
  logic [31:0] load_data;

  assign rd_word  = mem[word_idx];
  assign rd_shift = rd_word >> {offset, 3'b000};

  // NOTE: every variable assigned in an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    load_data = rd_word;
    case (req_size)
      SZ_BYTE: load_data = req_unsigned ? {24'h0, rd_shift[7:0]}
                                        : {{24{rd_shift[7]}}, rd_shift[7:0]};
      SZ_HALF: load_data = req_unsigned ? {16'h0, rd_shift[15:0]}
                                        : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: load_data = rd_word;
    endcase
  end

  // Write port is shared between the INIT clear sweep and accepted stores.
  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = word_idx;
    wr_be   = 4'h0;
    wr_data = 32'h0;
    if (state_q == ST_INIT) begin
      wr_en  = 1'b1;
      wr_idx = clr_idx_q;
      wr_be  = 4'hF;
    end else if (accept && req_we && !req_err) begin
      wr_en = 1'b1;
      case (req_size)
        SZ_BYTE: begin
          wr_be   = 4'b0001 << offset;
          wr_data = {4{req_wdata[7:0]}};
        end
        SZ_HALF: begin
          wr_be   = 4'b0011 << offset;
          wr_data = {2{req_wdata[15:0]}};
        end
        default: begin
          wr_be   = 4'hF;
          wr_data = req_wdata;
        end
      endcase
    end
  end

  // NOTE: the array has no reset; clearing it is the job of the INIT sweep, which keeps
  // the storage mappable onto plain RAM without a reset network.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Next-state and response logic
  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    err_cnt_d   = err_cnt_q;
    rsp_valid_d = accept;
    rsp_rdata_d = 32'h0;
    rsp_err_d   = 1'b0;

    if (state_q == ST_INIT) begin
      if (clr_idx_q == AW'(DEPTH - 1)) begin
        state_d   = ST_RUN;
        clr_idx_d = '0;
      end else begin
        clr_idx_d = clr_idx_q + AW'(1);
      end
    end

    if (accept) begin
      if (req_err) begin
        rsp_err_d = 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end else if (!req_we) begin
        rsp_rdata_d = load_data;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      clr_idx_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= 8'h0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign req_ready = (state_q == ST_RUN);
  assign init_done = (state_q == ST_RUN);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed vector table, randomized traffic against a
// byte-array reference model, and hand-written reset/saturation sequences.
module tb_data_mem_ctrl;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 32;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              init_done;
  logic [7:0]        err_cnt;

  data_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .init_done    (init_done),
    .err_cnt      (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: plain byte-addressed array plus a saturating error count.
  logic [7:0] mm [DEPTH*4];
  int         m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH*4; i++) mm[i] = 8'h00;
    m_err = 0;
  endtask

  function automatic void model_access(input logic we, input logic [1:0] size,
                                       input logic uns, input logic [31:0] addr,
                                       input logic [31:0] wdata,
                                       output logic [31:0] rdata, output logic err);
    int          n;
    logic [31:0] v;
    n     = 1 << size;
    err   = (size == 2'b11) || ((addr % n) != 0) || ((addr / 4) >= DEPTH);
    rdata = 32'h0;
    if (err) begin
      if (m_err < 255) m_err++;
    end else if (we) begin
      for (int k = 0; k < n; k++) mm[addr + k] = wdata[8*k +: 8];
    end else begin
      v = 32'h0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = mm[addr + k];
      if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
      rdata = v;
    end
  endfunction

  // One request accepted on the next rising edge; response checked #1 after that edge.
  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] got_rdata, output logic got_err);
    logic [31:0] exp_r;
    logic        exp_e;
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    model_access(we, size, uns, addr, wdata, exp_r, exp_e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    got_rdata = rsp_rdata;
    got_err   = rsp_err;
    check({tag, ".rsp_valid"}, {31'h0, rsp_valid}, 32'h1);
    check({tag, ".rdata"}, rsp_rdata, exp_r);
    check({tag, ".err"}, {31'h0, rsp_err}, {31'h0, exp_e});
    check({tag, ".err_cnt"}, {24'h0, err_cnt}, 32'(m_err));
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = $urandom;
    req_wdata = $urandom;
    @(posedge clk);
    #1;
    check("idle.rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("idle.rdata", rsp_rdata, 32'h0);
    check("idle.err", {31'h0, rsp_err}, 32'h0);
  endtask

  task automatic wait_init();
    for (int i = 0; i < 4*DEPTH && !init_done; i++) @(posedge clk);
    #1;
    check("init_done_within_bound", {31'h0, init_done}, 32'h1);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t        tbl [24];
  logic [31:0] got_r;
  logic        got_e;

  initial begin
    // we, size, uns, addr, wdata, exp_rdata, exp_err, exp_cnt
    tbl[0]  = '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'h00000000, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 2'b10, 1'b0, 32'h04,  32'h800000F0, 32'h00000000, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 2'b00, 1'b0, 32'h07,  32'h0,        32'hFFFFFF80, 1'b0, 8'd0};
    tbl[3]  = '{1'b0, 2'b00, 1'b1, 32'h07,  32'h0,        32'h00000080, 1'b0, 8'd0};
    tbl[4]  = '{1'b0, 2'b01, 1'b0, 32'h06,  32'h0,        32'hFFFF8000, 1'b0, 8'd0};
    tbl[5]  = '{1'b0, 2'b01, 1'b1, 32'h04,  32'h0,        32'h000000F0, 1'b0, 8'd0};
    tbl[6]  = '{1'b1, 2'b00, 1'b0, 32'h05,  32'h123456AB, 32'h00000000, 1'b0, 8'd0};
    tbl[7]  = '{1'b0, 2'b10, 1'b0, 32'h04,  32'h0,        32'h8000ABF0, 1'b0, 8'd0};
    tbl[8]  = '{1'b0, 2'b10, 1'b0, 32'h02,  32'h0,        32'h00000000, 1'b1, 8'd1};
    tbl[9]  = '{1'b1, 2'b10, 1'b0, 32'h08,  32'h11223344, 32'h00000000, 1'b0, 8'd1};
    tbl[10] = '{1'b1, 2'b01, 1'b0, 32'h09,  32'h0000FFFF, 32'h00000000, 1'b1, 8'd2};
    tbl[11] = '{1'b0, 2'b10, 1'b0, 32'h08,  32'h0,        32'h11223344, 1'b0, 8'd2};
    tbl[12] = '{1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        32'h00000000, 1'b1, 8'd3};
    tbl[13] = '{1'b0, 2'b11, 1'b0, 32'h0C,  32'h0,        32'h00000000, 1'b1, 8'd4};
    tbl[14] = '{1'b1, 2'b10, 1'b0, 32'h20,  32'hDEADBEEF, 32'h00000000, 1'b0, 8'd4};
    tbl[15] = '{1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'hDEADBEEF, 1'b0, 8'd4};
    tbl[16] = '{1'b0, 2'b00, 1'b0, 32'h04,  32'h0,        32'hFFFFFFF0, 1'b0, 8'd4};
    tbl[17] = '{1'b0, 2'b01, 1'b1, 32'h06,  32'h0,        32'h00008000, 1'b0, 8'd4};
    tbl[18] = '{1'b1, 2'b01, 1'b0, 32'h22,  32'h0000CAFE, 32'h00000000, 1'b0, 8'd4};
    tbl[19] = '{1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'hCAFEBEEF, 1'b0, 8'd4};
    tbl[20] = '{1'b1, 2'b10, 1'b0, 32'hFC,  32'hA5A5A5A5, 32'h00000000, 1'b0, 8'd4};
    tbl[21] = '{1'b0, 2'b01, 1'b0, 32'hFE,  32'h0,        32'hFFFFA5A5, 1'b0, 8'd4};
    tbl[22] = '{1'b0, 2'b00, 1'b1, 32'hFF,  32'h0,        32'h000000A5, 1'b0, 8'd4};
    tbl[23] = '{1'b1, 2'b00, 1'b0, 32'h100, 32'h000000FF, 32'h00000000, 1'b1, 8'd5};

    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    rst_n        = 1'b0;
    model_clear();

    // Outputs while reset is held
    #1;
    check("rst.req_ready", {31'h0, req_ready}, 32'h0);
    check("rst.rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst.rdata", rsp_rdata, 32'h0);
    check("rst.err", {31'h0, rsp_err}, 32'h0);
    check("rst.init_done", {31'h0, init_done}, 32'h0);
    check("rst.err_cnt", {24'h0, err_cnt}, 32'h0);

    // Release at a falling edge; init must finish exactly on the DEPTH-th rising edge.
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      @(posedge clk);
      #1;
      if (i == DEPTH - 1) begin
        check("init.done_before_last", {31'h0, init_done}, 32'h0);
        check("init.ready_before_last", {31'h0, req_ready}, 32'h0);
      end
      if (i == DEPTH) begin
        check("init.done_at_last", {31'h0, init_done}, 32'h1);
        check("init.ready_at_last", {31'h0, req_ready}, 32'h1);
      end
    end

    // Directed table, issued back to back
    for (int v = 0; v < 24; v++) begin
      do_req($sformatf("tbl%0d", v), tbl[v].we, tbl[v].size, tbl[v].uns, tbl[v].addr,
             tbl[v].wdata, got_r, got_e);
      check($sformatf("tbl%0d.exp_rdata", v), got_r, tbl[v].exp_rdata);
      check($sformatf("tbl%0d.exp_err", v), {31'h0, got_e}, {31'h0, tbl[v].exp_err});
      check($sformatf("tbl%0d.exp_cnt", v), {24'h0, err_cnt}, {24'h0, tbl[v].exp_cnt});
    end
    idle_cycle();

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      if ($urandom_range(0, 5) == 0) begin
        idle_cycle();
      end else begin
        sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        case ($urandom_range(0, 9))
          0:       a = $urandom;
          1:       a = 32'(DEPTH*4) + 32'($urandom_range(0, 64));
          2, 3, 4: a = 32'($urandom_range(0, 31));
          default: a = 32'($urandom_range(0, DEPTH*4 - 1));
        endcase
        if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~((32'h1 << sz) - 32'h1);
        do_req($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), sz,
               1'($urandom_range(0, 1)), a, $urandom, got_r, got_e);
      end
    end

    // Reset asserted while a load response is on the outputs
    do_req("pre_rst.sw", 1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, got_r, got_e);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = 2'b10;
    req_addr  = 32'h20;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("mid_rst.rsp_due", {31'h0, rsp_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst.rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("mid_rst.rdata", rsp_rdata, 32'h0);
    check("mid_rst.ready", {31'h0, req_ready}, 32'h0);
    check("mid_rst.init_done", {31'h0, init_done}, 32'h0);
    check("mid_rst.err_cnt", {24'h0, err_cnt}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    wait_init();
    do_req("post_rst.lw20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, got_r, got_e);
    check("post_rst.lw20_zero", got_r, 32'h0);
    do_req("post_rst.lwFC", 1'b0, 2'b10, 1'b0, 32'hFC, 32'h0, got_r, got_e);

    // Error counter saturation
    for (int n = 0; n < 300; n++) begin
      do_req("sat", 1'($urandom_range(0, 1)), 2'b11, 1'b0, $urandom, $urandom, got_r, got_e);
    end
    check("sat.err_cnt_255", {24'h0, err_cnt}, 32'd255);
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time limit so the bench always ends on its own.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
